// File: rtl/mygo_chan_recv.sv
// mygo_chan_recv: receive endpoint at the consumer end of a mygo channel FIFO.
// Converts a blocking "v, ok := <-ch" request into a single valid/ready pop
// and reports (data, ok). Close is sticky and only reported once the channel
// has drained, so buffered elements are always delivered before ok=0.
// Optional build macro: MYGO_CHAN_RECV_PREFETCH_EN adds a one-entry prefetch
// register. While idle it pops one element ahead of time, so a receive can
// complete one cycle after the request.
//
//   state | meaning
//   IDLE  | no receive pending, waiting for recv_req
//   WAIT  | receive pending, blocked until data or drained close
//   DONE  | result registered, recv_done pulses this cycle
module mygo_chan_recv #(
    parameter int WIDTH      = 32,
    parameter int COUNT_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      fifo_data,
    input  logic                  fifo_valid,
    output logic                  fifo_ready,
    input  logic                  close_req,
    input  logic                  recv_req,
    output logic                  recv_busy,
    output logic                  recv_done,
    output logic [WIDTH-1:0]      recv_data,
    output logic                  recv_ok,
    output logic                  closed,
    output logic [COUNT_BITS-1:0] recv_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      data_q, data_d;
    logic                  ok_q, ok_d;
    logic                  closed_q, closed_d;
    logic [COUNT_BITS-1:0] count_q, count_d;
    logic                  pop;

`ifdef MYGO_CHAN_RECV_PREFETCH_EN
    logic [WIDTH-1:0]      pf_data_q, pf_data_d;
    logic                  pf_valid_q, pf_valid_d;
`endif

    // Next-state, result capture and pop strobe.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        ok_d     = ok_q;
        count_d  = count_q;
        closed_d = closed_q | close_req;
        pop      = 1'b0;
`ifdef MYGO_CHAN_RECV_PREFETCH_EN
        pf_data_d  = pf_data_q;
        pf_valid_d = pf_valid_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef MYGO_CHAN_RECV_PREFETCH_EN
                if (recv_req && pf_valid_q) begin
                    data_d     = pf_data_q;
                    ok_d       = 1'b1;
                    count_d    = count_q + 1'b1;
                    pf_valid_d = 1'b0;
                    state_d    = ST_DONE;
                end else if (recv_req) begin
                    state_d = ST_WAIT;
                end else if (!pf_valid_q && fifo_valid) begin
                    // Only prefetch when no request is arriving, so WAIT
                    // never has to arbitrate between two buffered elements.
                    pop        = 1'b1;
                    pf_data_d  = fifo_data;
                    pf_valid_d = 1'b1;
                end
`else
                if (recv_req) begin
                    state_d = ST_WAIT;
                end
`endif
            end
            ST_WAIT: begin
`ifdef MYGO_CHAN_RECV_PREFETCH_EN
                if (pf_valid_q) begin
                    data_d     = pf_data_q;
                    ok_d       = 1'b1;
                    count_d    = count_q + 1'b1;
                    pf_valid_d = 1'b0;
                    state_d    = ST_DONE;
                end else
`endif
                if (fifo_valid) begin
                    // Data wins over close: the channel is not drained yet.
                    pop     = 1'b1;
                    data_d  = fifo_data;
                    ok_d    = 1'b1;
                    count_d = count_q + 1'b1;
                    state_d = ST_DONE;
                end else if (closed_q) begin
                    data_d  = '0;
                    ok_d    = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            ok_q     <= 1'b0;
            closed_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            ok_q     <= ok_d;
            closed_q <= closed_d;
            count_q  <= count_d;
        end
    end

`ifdef MYGO_CHAN_RECV_PREFETCH_EN
    // Prefetch slot; a prefetched element is discarded by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pf_data_q  <= '0;
            pf_valid_q <= 1'b0;
        end else begin
            pf_data_q  <= pf_data_d;
            pf_valid_q <= pf_valid_d;
        end
    end
`endif

    // The pop strobe is gated by reset so nothing leaves the FIFO while held.
    assign fifo_ready = pop & rst;
    assign recv_busy  = (state_q != ST_IDLE);
    assign recv_done  = (state_q == ST_DONE);
    assign recv_data  = data_q;
    assign recv_ok    = ok_q;
    assign closed     = closed_q;
    assign recv_count = count_q;

endmodule

// File: tb/tb_mygo_chan_recv.sv
module tb_mygo_chan_recv;

`ifdef MYGO_CHAN_RECV_PREFETCH_EN
    localparam int LAT_D = 1;
`else
    localparam int LAT_D = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fifo_data;
    logic        fifo_valid;
    logic        fifo_ready;
    logic        close_req;
    logic        recv_req;
    logic        recv_busy;
    logic        recv_done;
    logic [31:0] recv_data;
    logic        recv_ok;
    logic        closed;
    logic [15:0] recv_count;

    // Small-counter instance used only for the wrap check.
    logic        w_req;
    logic        w_ready, w_busy, w_done, w_ok, w_closed;
    logic [7:0]  w_data;
    logic [3:0]  w_count;

    always #5 clk = ~clk;

    mygo_chan_recv #(.WIDTH(32), .COUNT_BITS(16)) dut (
        .clk(clk), .rst(rst),
        .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_ready(fifo_ready),
        .close_req(close_req), .recv_req(recv_req),
        .recv_busy(recv_busy), .recv_done(recv_done), .recv_data(recv_data),
        .recv_ok(recv_ok), .closed(closed), .recv_count(recv_count)
    );

    mygo_chan_recv #(.WIDTH(8), .COUNT_BITS(4)) u_wrap (
        .clk(clk), .rst(rst),
        .fifo_data(8'h5A), .fifo_valid(1'b1), .fifo_ready(w_ready),
        .close_req(1'b0), .recv_req(w_req),
        .recv_busy(w_busy), .recv_done(w_done), .recv_data(w_data),
        .recv_ok(w_ok), .closed(w_closed), .recv_count(w_count)
    );

    typedef struct {
        bit          do_push;
        logic [31:0] val;
        bit          do_close;
        bit          do_recv;
        logic [31:0] exp_data;
        bit          exp_ok;
        int          exp_lat;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    int          pops  = 0;
    int          dones = 0;
    logic [31:0] fq[$];
    logic [31:0] sent[$];
    logic [15:0] exp_count;
    bit          exp_closed;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_valid = (fq.size() != 0);
        fifo_data  = fifo_valid ? fq[0] : 32'h0;
    endtask

    // One clock: inputs set by the caller at the negedge, FIFO model pops on a
    // sampled handshake, pulses cleared at the following negedge.
    task automatic cyc();
        bit p;
        drive_fifo();
        #1;
        p = fifo_ready && fifo_valid;
        @(posedge clk);
        if (p) begin
            void'(fq.pop_front());
            pops++;
        end
        @(negedge clk);
        recv_req  = 1'b0;
        close_req = 1'b0;
        w_req     = 1'b0;
        if (recv_done) dones++;
    endtask

    task automatic do_recv(output int lat);
        recv_req = 1'b1;
        cyc();
        lat = 1;
        while (!recv_done && lat < 20) begin
            cyc();
            lat++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[7];
        int          lat;
        bit          busy_ok;
        bit          outstanding;
        bit          closed_m;
        bit          saw_eof;
        logic [31:0] v;
        logic [3:0]  wexp;

        tbl[0] = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, LAT_D};
        tbl[1] = '{1'b1, 32'h1,        1'b0, 1'b0, 32'h0,        1'b0, 0};
        tbl[2] = '{1'b1, 32'h2,        1'b1, 1'b0, 32'h0,        1'b0, 0};
        tbl[3] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h1,        1'b1, LAT_D};
        tbl[4] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h2,        1'b1, LAT_D};
        tbl[5] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 2};
        tbl[6] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 2};

        rst = 1'b0; recv_req = 1'b0; close_req = 1'b0; w_req = 1'b0;
        fifo_valid = 1'b0; fifo_data = 32'h0;
        exp_count = 16'h0; exp_closed = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_busy",   recv_busy, 0);
        chk("reset_done",   recv_done, 0);
        chk("reset_ready",  fifo_ready, 0);
        chk("reset_data",   recv_data, 0);
        chk("reset_ok",     recv_ok, 0);
        chk("reset_closed", closed, 0);
        chk("reset_count",  recv_count, 0);
        rst = 1'b1;
        cyc();

        // Reset in the middle of a pending receive.
        fq.push_back(32'hA5);
        cyc(); cyc();
        do_recv(lat);
        exp_count++;
        chk("pre_done",  recv_done, 1);
        chk("pre_data",  recv_data, 32'hA5);
        chk("pre_count", recv_count, exp_count);
        cyc();
        recv_req = 1'b1;
        cyc(); cyc(); cyc();
        chk("rst_pre_busy", recv_busy, 1);
        fq.push_back(32'h77);
        drive_fifo();
        rst = 1'b0;
        #1;
        chk("rst_busy",  recv_busy, 0);
        chk("rst_ready", fifo_ready, 0);
        chk("rst_done",  recv_done, 0);
        chk("rst_data",  recv_data, 0);
        chk("rst_ok",    recv_ok, 0);
        chk("rst_count", recv_count, 0);
        pops = 0; dones = 0;
        cyc(); cyc();
        rst = 1'b1;
        exp_count = 16'h0;
        cyc(); cyc(); cyc();
`ifndef MYGO_CHAN_RECV_PREFETCH_EN
        chk("rst_no_pop", pops, 0);
`endif
        chk("rst_no_done", dones, 0);
        do_recv(lat);
        exp_count++;
        chk("post_rst_data",  recv_data, 32'h77);
        chk("post_rst_ok",    recv_ok, 1);
        chk("post_rst_count", recv_count, exp_count);
        cyc();

        // Blocking receive on an empty channel.
        pops = 0; dones = 0;
        recv_req = 1'b1;
        cyc();
        busy_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!recv_busy || recv_done) busy_ok = 1'b0;
            cyc();
        end
        chk("block_busy", busy_ok, 1);
        fq.push_back(32'h5);
        lat = 0;
        while (!recv_done && lat < 20) begin
            cyc();
            lat++;
        end
        exp_count++;
        chk("block_done",  recv_done, 1);
        chk("block_data",  recv_data, 32'h5);
        chk("block_ok",    recv_ok, 1);
        chk("block_pops",  pops, 1);
        chk("block_count", recv_count, exp_count);
        cyc();

        // Extra requests during WAIT and DONE are dropped.
        pops = 0; dones = 0;
        recv_req = 1'b1; cyc();
        recv_req = 1'b1; cyc();
        fq.push_back(32'h33);
        recv_req = 1'b1; cyc();
        exp_count++;
        chk("ign_data", recv_data, 32'h33);
        recv_req = 1'b1; cyc();
        cyc(); cyc(); cyc();
        chk("ign_dones", dones, 1);
        chk("ign_pops",  pops, 1);
        chk("ign_busy",  recv_busy, 0);
        chk("ign_count", recv_count, exp_count);

        // Table-driven receive/close sequence.
        for (int k = 0; k < 7; k++) begin
            if (tbl[k].do_push) fq.push_back(tbl[k].val);
            cyc();
            if (tbl[k].do_close) begin
                close_req  = 1'b1;
                exp_closed = 1'b1;
                cyc();
            end
            cyc(); cyc(); cyc();
            if (tbl[k].do_recv) begin
                do_recv(lat);
                if (tbl[k].exp_ok) exp_count++;
                chk($sformatf("tbl%0d_done", k),   recv_done, 1);
                chk($sformatf("tbl%0d_lat", k),    lat, tbl[k].exp_lat);
                chk($sformatf("tbl%0d_data", k),   recv_data, tbl[k].exp_data);
                chk($sformatf("tbl%0d_ok", k),     recv_ok, tbl[k].exp_ok);
                chk($sformatf("tbl%0d_count", k),  recv_count, exp_count);
                chk($sformatf("tbl%0d_closed", k), closed, exp_closed);
                cyc();
            end
        end

        // Randomized traffic against a channel-level model.
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        fq.delete(); sent.delete();
        cyc();
        exp_count = 16'h0; closed_m = 1'b0; outstanding = 1'b0; saw_eof = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (c >= 800 && !outstanding && sent.size() == 0 && saw_eof) break;
            if (recv_done) begin
                if (!outstanding) begin
                    chk("rnd_spurious_done", recv_done, 0);
                end else if (sent.size() != 0) begin
                    v = sent.pop_front();
                    exp_count++;
                    chk("rnd_ok",    recv_ok, 1);
                    chk("rnd_data",  recv_data, v);
                    chk("rnd_count", recv_count, exp_count);
                end else begin
                    chk("rnd_eof_ok",    recv_ok, 0);
                    chk("rnd_eof_data",  recv_data, 0);
                    chk("rnd_eof_early", closed_m, 1);
                    chk("rnd_eof_count", recv_count, exp_count);
                    saw_eof = 1'b1;
                end
                outstanding = 1'b0;
                if ($urandom_range(0, 1) == 0) recv_req = 1'b1;
            end else if (!outstanding) begin
                if (c >= 800 || $urandom_range(0, 3) != 0) begin
                    recv_req    = 1'b1;
                    outstanding = 1'b1;
                end
            end else if ($urandom_range(0, 4) == 0) begin
                recv_req = 1'b1;
            end
            if (c < 590 && $urandom_range(0, 3) == 0) begin
                v = $urandom;
                fq.push_back(v);
                sent.push_back(v);
            end
            if (c == 600) begin
                close_req = 1'b1;
                closed_m  = 1'b1;
            end
            cyc();
        end
        chk("rnd_drained", (sent.size() == 0) && saw_eof && !outstanding, 1);
        chk("rnd_closed",  closed, closed_m);

        // Counter wrap on a 4-bit instance.
        wexp = 4'h0;
        for (int i = 0; i < 16; i++) begin
            w_req = 1'b1;
            cyc(); cyc(); cyc();
            wexp++;
            chk($sformatf("wrap_count%0d", i), w_count, wexp);
        end
        chk("wrap_ok", w_ok, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mygo_chan_recv.md
Name: mygo_chan_recv

Overview:
- Receive endpoint for a mygo channel: the reader at the consumer end of a channel FIFO.
- Turns a process's blocking "v, ok := <-ch" request into a valid/ready pop on the FIFO output side (out_data/out_valid/out_ready).
- Tracks sticky channel-close with Go drain-then-close semantics: buffered data is delivered before ok=0.
- Sits between a generated process FSM and a mygo_fifo_iW_dN instance.

Parameters:
WIDTH, 32, channel element width in bits
COUNT_BITS, 16, width of the successful-receive counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
fifo_data  input  WIDTH  FIFO out_data
fifo_valid  input  1  FIFO out_valid
fifo_ready  output  1  FIFO out_ready (pop strobe)
close_req  input  1  one-cycle pulse from sender: channel closed
recv_req  input  1  one-cycle pulse from process: start a receive
recv_busy  output  1  receive in progress; recv_req ignored while high
recv_done  output  1  one-cycle pulse: result valid this cycle
recv_data  output  WIDTH  received element, registered, held until next done
recv_ok  output  1  1 = real element, 0 = channel closed and drained
closed  output  1  sticky close flag
recv_count  output  COUNT_BITS  number of ok=1 completions, wraps modulo 2^COUNT_BITS

Behaviour:
- Reset (rst=0, async) forces: state IDLE, fifo_ready=0, recv_busy=0, recv_done=0, recv_data=0, recv_ok=0, closed=0, recv_count=0.
- Reset mid-transaction drops the pending receive without a recv_done pulse.
- FSM states:
  - IDLE: recv_req=1 -> WAIT.
  - WAIT: if fifo_valid=1, assert fifo_ready combinationally this cycle, capture recv_data<=fifo_data, recv_ok<=1, then -> DONE.
  - WAIT: else if closed=1, capture recv_data<=0, recv_ok<=0, then -> DONE.
  - WAIT: else stay (block).
  - DONE: recv_done=1 for exactly one cycle, then -> IDLE.
- recv_busy = (state != IDLE). recv_req in WAIT or DONE is ignored, not queued.
- fifo_ready is 1 only in WAIT with fifo_valid=1, so at most one pop per request; it is never asserted in IDLE or DONE.
- Latency: recv_req at cycle t with data present -> pop at t+1, recv_done at t+2. Minimum 2 cycles, unbounded while the channel is empty and open.
- Data takes priority over close: if fifo_valid=1 and closed=1 in WAIT, the data is delivered with ok=1.
- Sender contract: close_req is pulsed no earlier than the cycle after its last push handshake; this guarantees no element is lost behind close.
- closed is set on close_req and stays set until reset; repeated close_req has no effect.
- close_req arriving in the same cycle WAIT sees an empty FIFO takes effect next cycle; the receive completes one cycle later.
- recv_count increments by 1 on each DONE entry with ok=1; it wraps from all-ones to 0. No change on ok=0 completions.
- recv_data and recv_ok hold their last values outside DONE.

Optional Feature:
MYGO_CHAN_RECV_PREFETCH_EN
- Defined: adds a one-entry prefetch register pf_data/pf_valid.
  - In IDLE with pf_valid=0 and fifo_valid=1, pop one element into pf (fifo_ready=1 that cycle).
  - recv_req in IDLE with pf_valid=1 goes straight to DONE with data=pf_data, ok=1, clears pf_valid; recv_done at t+1.
  - Close reports ok=0 only when closed=1, pf_valid=0 and fifo_valid=0.
  - Reset clears pf_valid; the prefetched element is lost.
- Undefined: no prefetch storage, fifo_ready only in WAIT, 2-cycle minimum latency as above.

Test Plan:
- Reset with rst=0 mid-WAIT, data present -> all outputs 0 immediately, no recv_done, no pop on release.
- FIFO holds 0xDEADBEEF, recv_req at t -> fifo_ready=1 at t+1 only, recv_done at t+2 with recv_data=0xDEADBEEF, recv_ok=1, recv_count=1.
- Empty FIFO, recv_req, wait 10 cycles, then fifo_valid with 0x5 -> busy throughout, single pop, done with data 5, ok=1.
- Push 0x1,0x2 then close_req, issue 3 receives -> (1,ok=1), (2,ok=1), (0,ok=0); closed=1; recv_count=2.
- recv_req pulsed again during WAIT and DONE -> ignored, exactly one pop and one done. Preload recv_count to 0xFFFF, one ok=1 receive -> recv_count=0x0000.
- With MYGO_CHAN_RECV_PREFETCH_EN, FIFO holds 0x7, idle 3 cycles then recv_req at t -> recv_done at t+1, data 7, ok=1. Without the macro -> recv_done at t+2.
